// File: rtl/alu_rs_pkg.sv
// Shared op encodings, ROB tag type and the CDB capture helper for the ALU reservation station.
package alu_rs_pkg;

   localparam int OP_W  = 6;
   localparam int ROB_W = 4;

   typedef enum logic [OP_W-1:0] {
      OPENUM_NOP = 6'd0,
      OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
      OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
      OPENUM_ADD, OPENUM_SUB, OPENUM_AND, OPENUM_OR, OPENUM_XOR,
      OPENUM_SLL, OPENUM_SRL, OPENUM_SRA, OPENUM_SLT, OPENUM_SLTU
   } openum_e;

   localparam logic [ROB_W-1:0] ZERO_ROB  = '0;
   localparam logic [31:0]      ZERO_WORD = '0;

   typedef struct packed {
      logic [ROB_W-1:0] tag;
      logic [31:0]      val;
   } opnd_t;

   // Operand capture from the two result buses; ALU bus wins, a zero bus tag never matches.
   function automatic opnd_t cdb_fwd(input logic [ROB_W-1:0] tag, input logic [31:0] val,
                                     input logic [ROB_W-1:0] alu_tag, input logic [31:0] alu_val,
                                     input logic [ROB_W-1:0] lsb_tag, input logic [31:0] lsb_val);
      opnd_t r;
      r.tag = tag;
      r.val = val;
      if (tag != ZERO_ROB) begin
         if (tag == alu_tag) begin
            r.tag = ZERO_ROB;
            r.val = alu_val;
         end else if (tag == lsb_tag) begin
            r.tag = ZERO_ROB;
            r.val = lsb_val;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-set-bit encoder: index of the first set request bit plus a found flag.
module rs_prio_enc #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the shared ALU: buffers dispatched ops, wakes operands from both CDBs,
// issues the lowest-index ready entry per cycle into registered ALU operand outputs.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_SIZE  = 8,
   parameter int RS_IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             in_clear,
   input  logic             in_disp_en,
   input  logic [OP_W-1:0]  in_disp_op,
   input  logic [31:0]      in_disp_val1,
   input  logic [31:0]      in_disp_val2,
   input  logic [ROB_W-1:0] in_disp_tag1,
   input  logic [ROB_W-1:0] in_disp_tag2,
   input  logic [31:0]      in_disp_imm,
   input  logic [31:0]      in_disp_pc,
   input  logic [ROB_W-1:0] in_disp_rob_tag,
   input  logic [ROB_W-1:0] in_alu_cdb_tag,
   input  logic [31:0]      in_alu_cdb_val,
   input  logic [ROB_W-1:0] in_lsb_cdb_tag,
   input  logic [31:0]      in_lsb_cdb_val,
   output logic             out_full,
   output logic [OP_W-1:0]  out_op,
   output logic [31:0]      out_value1,
   output logic [31:0]      out_value2,
   output logic [31:0]      out_imm,
   output logic [31:0]      out_pc,
   output logic [ROB_W-1:0] out_rob_tag
);

   logic [RS_SIZE-1:0] valid;
   logic [OP_W-1:0]    op_q   [RS_SIZE];
   logic [31:0]        val1_q [RS_SIZE];
   logic [31:0]        val2_q [RS_SIZE];
   logic [ROB_W-1:0]   tag1_q [RS_SIZE];
   logic [ROB_W-1:0]   tag2_q [RS_SIZE];
   logic [31:0]        imm_q  [RS_SIZE];
   logic [31:0]        pc_q   [RS_SIZE];
   logic [ROB_W-1:0]   rtag_q [RS_SIZE];

   opnd_t              wk1 [RS_SIZE];
   opnd_t              wk2 [RS_SIZE];
   logic [RS_SIZE-1:0] ready;
   logic [RS_SIZE-1:0] free_vec;
   opnd_t              disp1;
   opnd_t              disp2;
   logic [RS_IDX_W-1:0] free_idx;
   logic [RS_IDX_W-1:0] iss_idx;
   logic               free_found;
   logic               iss_found;

   genvar g;
   generate
      for (g = 0; g < RS_SIZE; g++) begin : g_entry
         assign wk1[g] = cdb_fwd(tag1_q[g], val1_q[g], in_alu_cdb_tag, in_alu_cdb_val,
                                 in_lsb_cdb_tag, in_lsb_cdb_val);
         assign wk2[g] = cdb_fwd(tag2_q[g], val2_q[g], in_alu_cdb_tag, in_alu_cdb_val,
                                 in_lsb_cdb_tag, in_lsb_cdb_val);
         // Readiness looks at registered tags only, so a wakeup issues one edge later.
         assign ready[g] = valid[g] && (tag1_q[g] == ZERO_ROB) && (tag2_q[g] == ZERO_ROB);
      end
   endgenerate

   assign disp1 = cdb_fwd(in_disp_tag1, in_disp_val1, in_alu_cdb_tag, in_alu_cdb_val,
                          in_lsb_cdb_tag, in_lsb_cdb_val);
   assign disp2 = cdb_fwd(in_disp_tag2, in_disp_val2, in_alu_cdb_tag, in_alu_cdb_val,
                          in_lsb_cdb_tag, in_lsb_cdb_val);

   assign free_vec = ~valid;
   assign out_full = &valid;

   rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (
      .req   (free_vec),
      .idx   (free_idx),
      .found (free_found)
   );

   rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_issue_enc (
      .req   (ready),
      .idx   (iss_idx),
      .found (iss_found)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid       <= '0;
         out_op      <= OPENUM_NOP;
         out_value1  <= ZERO_WORD;
         out_value2  <= ZERO_WORD;
         out_imm     <= ZERO_WORD;
         out_pc      <= ZERO_WORD;
         out_rob_tag <= ZERO_ROB;
      end else if (rdy) begin
         if (in_clear) begin
            valid       <= '0;
            out_op      <= OPENUM_NOP;
            out_rob_tag <= ZERO_ROB;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (valid[i]) begin
                  tag1_q[i] <= wk1[i].tag;
                  val1_q[i] <= wk1[i].val;
                  tag2_q[i] <= wk2[i].tag;
                  val2_q[i] <= wk2[i].val;
               end
            end

            if (iss_found) begin
               out_op           <= op_q[iss_idx];
               out_value1       <= val1_q[iss_idx];
               out_value2       <= val2_q[iss_idx];
               out_imm          <= imm_q[iss_idx];
               out_pc           <= pc_q[iss_idx];
               out_rob_tag      <= rtag_q[iss_idx];
               valid[iss_idx]   <= 1'b0;
            end else begin
               out_op      <= OPENUM_NOP;
               out_rob_tag <= ZERO_ROB;
            end

            // Free slot comes from pre-edge valid bits, so it can never be the issuing slot.
            if (in_disp_en && free_found) begin
               valid[free_idx]  <= 1'b1;
               op_q[free_idx]   <= in_disp_op;
               tag1_q[free_idx] <= disp1.tag;
               val1_q[free_idx] <= disp1.val;
               tag2_q[free_idx] <= disp2.tag;
               val2_q[free_idx] <= disp2.val;
               imm_q[free_idx]  <= in_disp_imm;
               pc_q[free_idx]   <= in_disp_pc;
               rtag_q[free_idx] <= in_disp_rob_tag;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Directed-vector bench for alu_rs with hand-computed expectations.
module tb_alu_rs;
   import alu_rs_pkg::*;

   logic             clk = 1'b0;
   logic             rst, rdy, in_clear, in_disp_en;
   logic [OP_W-1:0]  in_disp_op;
   logic [31:0]      in_disp_val1, in_disp_val2, in_disp_imm, in_disp_pc;
   logic [ROB_W-1:0] in_disp_tag1, in_disp_tag2, in_disp_rob_tag;
   logic [ROB_W-1:0] in_alu_cdb_tag, in_lsb_cdb_tag;
   logic [31:0]      in_alu_cdb_val, in_lsb_cdb_val;
   logic             out_full;
   logic [OP_W-1:0]  out_op;
   logic [31:0]      out_value1, out_value2, out_imm, out_pc;
   logic [ROB_W-1:0] out_rob_tag;

   int n_chk  = 0;
   int n_fail = 0;

   alu_rs #(.RS_SIZE(8), .RS_IDX_W(3)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .in_clear(in_clear),
      .in_disp_en(in_disp_en), .in_disp_op(in_disp_op),
      .in_disp_val1(in_disp_val1), .in_disp_val2(in_disp_val2),
      .in_disp_tag1(in_disp_tag1), .in_disp_tag2(in_disp_tag2),
      .in_disp_imm(in_disp_imm), .in_disp_pc(in_disp_pc), .in_disp_rob_tag(in_disp_rob_tag),
      .in_alu_cdb_tag(in_alu_cdb_tag), .in_alu_cdb_val(in_alu_cdb_val),
      .in_lsb_cdb_tag(in_lsb_cdb_tag), .in_lsb_cdb_val(in_lsb_cdb_val),
      .out_full(out_full), .out_op(out_op), .out_value1(out_value1), .out_value2(out_value2),
      .out_imm(out_imm), .out_pc(out_pc), .out_rob_tag(out_rob_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_disp_en      = 1'b0;
      in_disp_op      = OPENUM_NOP;
      in_disp_val1    = '0;
      in_disp_val2    = '0;
      in_disp_tag1    = ZERO_ROB;
      in_disp_tag2    = ZERO_ROB;
      in_disp_imm     = '0;
      in_disp_pc      = '0;
      in_disp_rob_tag = ZERO_ROB;
      in_alu_cdb_tag  = ZERO_ROB;
      in_alu_cdb_val  = '0;
      in_lsb_cdb_tag  = ZERO_ROB;
      in_lsb_cdb_val  = '0;
   endtask

   task automatic disp(input logic [OP_W-1:0] op, input logic [31:0] v1, input logic [ROB_W-1:0] t1,
                       input logic [31:0] v2, input logic [ROB_W-1:0] t2, input logic [ROB_W-1:0] rob);
      in_disp_en      = 1'b1;
      in_disp_op      = op;
      in_disp_val1    = v1;
      in_disp_tag1    = t1;
      in_disp_val2    = v2;
      in_disp_tag2    = t2;
      in_disp_rob_tag = rob;
      in_disp_imm     = 32'h100 + 32'(rob);
      in_disp_pc      = 32'h1000 + 32'(rob) * 4;
   endtask

   initial begin
      rst = 1'b0;
      rdy = 1'b1;
      in_clear = 1'b0;
      idle();

      // reset and idle
      tick();
      tick();
      check("rst_op", 32'(out_op), 32'(OPENUM_NOP));
      check("rst_rob", 32'(out_rob_tag), 0);
      check("rst_full", 32'(out_full), 0);
      check("rst_val1", out_value1, 0);
      check("rst_pc", out_pc, 0);
      rst = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("idle_op", 32'(out_op), 32'(OPENUM_NOP));
         check("idle_rob", 32'(out_rob_tag), 0);
         check("idle_full", 32'(out_full), 0);
      end

      // ready dispatch
      disp(OPENUM_ADD, 5, ZERO_ROB, 7, ZERO_ROB, 4'd3);
      tick();
      idle();
      check("rd_n_op", 32'(out_op), 32'(OPENUM_NOP));
      tick();
      check("rd_op", 32'(out_op), 32'(OPENUM_ADD));
      check("rd_v1", out_value1, 5);
      check("rd_v2", out_value2, 7);
      check("rd_rob", 32'(out_rob_tag), 3);
      check("rd_imm", out_imm, 32'h103);
      check("rd_pc", out_pc, 32'h100c);
      tick();
      check("rd_n2_op", 32'(out_op), 32'(OPENUM_NOP));
      check("rd_n2_rob", 32'(out_rob_tag), 0);
      check("rd_n2_hold", out_value1, 5);

      // wakeup from ALU CDB after dispatch
      disp(OPENUM_SUB, 0, 4'd4, 1, ZERO_ROB, 4'd5);
      tick();
      idle();
      tick();
      check("wk_wait_op", 32'(out_op), 32'(OPENUM_NOP));
      in_alu_cdb_tag = 4'd4;
      in_alu_cdb_val = 10;
      tick();
      idle();
      check("wk_same_op", 32'(out_op), 32'(OPENUM_NOP));
      tick();
      check("wk_op", 32'(out_op), 32'(OPENUM_SUB));
      check("wk_v1", out_value1, 10);
      check("wk_v2", out_value2, 1);
      check("wk_rob", 32'(out_rob_tag), 5);
      tick();
      check("wk_done", 32'(out_op), 32'(OPENUM_NOP));

      // forwarding in the dispatch cycle from both buses
      disp(OPENUM_SUB, 0, 4'd4, 0, 4'd7, 4'd6);
      in_alu_cdb_tag = 4'd4;
      in_alu_cdb_val = 10;
      in_lsb_cdb_tag = 4'd7;
      in_lsb_cdb_val = 20;
      tick();
      idle();
      tick();
      check("fw_op", 32'(out_op), 32'(OPENUM_SUB));
      check("fw_v1", out_value1, 10);
      check("fw_v2", out_value2, 20);
      check("fw_rob", 32'(out_rob_tag), 6);
      tick();
      check("fw_done", 32'(out_op), 32'(OPENUM_NOP));

      // fill, drop, then LSB wakeup drains in index order
      for (int k = 0; k < 8; k++) begin
         check("fill_notfull", 32'(out_full), 0);
         disp(OPENUM_ADD, 0, 4'd6, 32'(k), ZERO_ROB, 4'(k + 1));
         tick();
      end
      check("fill_full", 32'(out_full), 1);
      disp(OPENUM_ADD, 0, 4'd6, 32'h99, ZERO_ROB, 4'd12);
      tick();
      idle();
      check("drop_full", 32'(out_full), 1);
      check("drop_op", 32'(out_op), 32'(OPENUM_NOP));
      in_lsb_cdb_tag = 4'd6;
      in_lsb_cdb_val = 100;
      tick();
      idle();
      check("bc_full", 32'(out_full), 1);
      check("bc_op", 32'(out_op), 32'(OPENUM_NOP));
      for (int k = 0; k < 8; k++) begin
         tick();
         check("drain_op", 32'(out_op), 32'(OPENUM_ADD));
         check("drain_rob", 32'(out_rob_tag), 32'(k + 1));
         check("drain_v1", out_value1, 100);
         check("drain_v2", out_value2, 32'(k));
         check("drain_full", 32'(out_full), 0);
      end
      tick();
      check("drain_end_op", 32'(out_op), 32'(OPENUM_NOP));
      check("drain_end_rob", 32'(out_rob_tag), 0);

      // clear with three ready entries
      for (int k = 0; k < 3; k++) begin
         disp(OPENUM_XOR, 0, 4'd9, 0, ZERO_ROB, 4'(k + 1));
         tick();
      end
      idle();
      in_alu_cdb_tag = 4'd9;
      in_alu_cdb_val = 32'h55;
      tick();
      idle();
      in_clear = 1'b1;
      tick();
      in_clear = 1'b0;
      check("clr_op", 32'(out_op), 32'(OPENUM_NOP));
      check("clr_rob", 32'(out_rob_tag), 0);
      check("clr_full", 32'(out_full), 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("clr_after_op", 32'(out_op), 32'(OPENUM_NOP));
      end

      // rdy low freezes everything and ignores dispatch
      disp(OPENUM_OR, 11, ZERO_ROB, 22, ZERO_ROB, 4'd7);
      tick();
      disp(OPENUM_AND, 33, ZERO_ROB, 44, ZERO_ROB, 4'd8);
      tick();
      check("rdy_a_rob", 32'(out_rob_tag), 7);
      disp(OPENUM_ADD, 1, ZERO_ROB, 2, ZERO_ROB, 4'd13);
      rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("frz_op", 32'(out_op), 32'(OPENUM_OR));
         check("frz_rob", 32'(out_rob_tag), 7);
         check("frz_v1", out_value1, 11);
      end
      idle();
      rdy = 1'b1;
      tick();
      check("res_op", 32'(out_op), 32'(OPENUM_AND));
      check("res_rob", 32'(out_rob_tag), 8);
      check("res_v2", out_value2, 44);
      tick();
      check("res_ignored", 32'(out_op), 32'(OPENUM_NOP));

      // reset with rdy low discards a pending entry and zeroes outputs
      disp(OPENUM_SLT, 3, ZERO_ROB, 4, ZERO_ROB, 4'd2);
      tick();
      idle();
      rdy = 1'b0;
      rst = 1'b0;
      tick();
      check("mrst_op", 32'(out_op), 32'(OPENUM_NOP));
      check("mrst_v1", out_value1, 0);
      check("mrst_v2", out_value2, 0);
      check("mrst_full", 32'(out_full), 0);
      rst = 1'b1;
      rdy = 1'b1;
      tick();
      check("mrst_after_op", 32'(out_op), 32'(OPENUM_NOP));
      check("mrst_after_rob", 32'(out_rob_tag), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station and issue scheduler for the single shared ALU. Buffers up to `RS_SIZE` decoded ALU/branch/jump ops from dispatch and captures missing operands from the two result broadcast buses (ALU and LSB). Each cycle it issues at most one ready entry to the ALU through a registered operand port. It sits between the dispatcher/ROB and the combinational ALU, and it alone drives the ALU inputs.

## Interface
- `RS_SIZE`, 8: number of entries; power of two, 2..16.
- `RS_IDX_W`, 3: log2(`RS_SIZE`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-low (asserted when 0).
- `rdy` input 1: global enable; when 0 all state including outputs holds, and dispatch/broadcast inputs are ignored.
- `in_clear` input 1: misprediction rollback; flush all entries.
- `in_disp_en` input 1: dispatch valid this cycle.
- `in_disp_op` input `OPENUM_TYPE`: op enum.
- `in_disp_val1`, `in_disp_val2` input 32: operand values, meaningful only when the matching tag is `ZERO_ROB`.
- `in_disp_tag1`, `in_disp_tag2` input `ROB_POS_TYPE`: producer ROB tag, or `ZERO_ROB` if the value is ready.
- `in_disp_imm` input 32, `in_disp_pc` input 32, `in_disp_rob_tag` input `ROB_POS_TYPE`.
- `in_alu_cdb_tag` input `ROB_POS_TYPE`, `in_alu_cdb_val` input 32: ALU result broadcast; `ZERO_ROB` means no broadcast.
- `in_lsb_cdb_tag` input `ROB_POS_TYPE`, `in_lsb_cdb_val` input 32: load result broadcast; same rule.
- `out_full` output 1: all entries valid; combinational from the registered valid bits.
- `out_op` output `OPENUM_TYPE`: registered; `OPENUM_NOP` when nothing is issued.
- `out_value1`, `out_value2`, `out_imm`, `out_pc` output 32: registered ALU operands.
- `out_rob_tag` output `ROB_POS_TYPE`: registered.

## Operation
- Entry state: `valid`, op, val1/tag1, val2/tag2, imm, pc, rob_tag. An entry is ready when valid, tag1 == `ZERO_ROB` and tag2 == `ZERO_ROB`.
- Wakeup: for every valid entry and each operand whose tag is not `ZERO_ROB`:
  - if the tag equals the ALU CDB tag, load the ALU value and set the tag to `ZERO_ROB`;
  - else if it equals the LSB CDB tag, load the LSB value likewise.
  - The ALU bus has priority; both buses carrying the same tag is illegal.
- Dispatch:
  - When `in_disp_en` and not `out_full`, write the lowest-index free entry.
  - The same CDB match is applied to the dispatched tags in that cycle (forwarding), so an operand broadcast in the dispatch cycle is never lost.
  - Dispatch while `out_full` is dropped silently; the dispatcher must not do it.
- Issue:
  - Select the lowest-index ready entry (fixed priority) from the registered state.
  - Copy its fields to the `out_*` registers and clear its valid bit at the same edge.
  - With no ready entry, `out_op` ← `OPENUM_NOP` and `out_rob_tag` ← `ZERO_ROB`; other `out_*` fields are don't-care but must hold their last value.
- Same-cycle events:
  - An entry freed by issue is not available to dispatch until the next cycle; the free search uses the pre-edge valid bits.
  - Wakeup and issue in the same cycle are independent; a just-woken entry issues no earlier than the next cycle.
- `in_clear` (with `rdy`=1): all valid ← 0, `out_op` ← NOP, `out_rob_tag` ← `ZERO_ROB`. `in_clear` overrides dispatch and issue in that cycle.
- Reset (`rst`=0 at the edge, regardless of `rdy`): same effect as clear, and all `out_*` data registers ← 0. Reset mid-operation discards every entry.

## Timing
- Dispatch of a fully ready op at edge N: issued at edge N+1; the ALU result is broadcast combinationally during cycle N+1..N+2. Minimum dispatch-to-result is 2 edges.
- Broadcast of the last missing operand in cycle t (captured at edge t): earliest issue at edge t+1.
- Back-to-back dependent ALU ops: the producer issues at edge E, its result is on `in_alu_cdb_*` during cycle E+1, and the consumer issues at edge E+2. This gives one bubble, which is accepted.
- Throughput: 1 issue/cycle, 1 dispatch/cycle.
- `out_full` changes only after an edge, never combinationally from the inputs.

## Structure
- `OPENUM_*`, `OPENUM_TYPE`, `ROB_POS_TYPE`, `ZERO_ROB`, `ZERO_WORD`: the shared defines header; nothing new is added there.
- One sub-module, `rs_prio_enc`: a parameterized lowest-index-set-bit encoder returning an index plus a found flag. It is instantiated twice, once for free-slot search and once for ready selection.
- The entry array is a set of per-field register vectors, with a generate loop for per-entry wakeup.

## Test plan
- Reset/idle: hold `rst`=0 for 2 cycles, then release with no dispatch → `out_op`=NOP, `out_rob_tag`=0 and `out_full`=0 for 10 cycles.
- Ready dispatch: ADD, val1=5, val2=7, both tags 0, rob_tag 3 at edge N → at edge N+1, `out_op`=ADD, `out_value1`=5, `out_value2`=7, `out_rob_tag`=3; NOP at edge N+2.
- Wakeup and forwarding:
  - Dispatch SUB with tag1=4, val2=1, then drive ALU CDB tag 4, value 10 → issue one edge after the broadcast with `out_value1`=10.
  - Repeat with the broadcast in the dispatch cycle itself → same result.
- Full and priority: fill all 8 entries, each with tag1=6 → `out_full`=1 and a 9th dispatch is dropped. Then broadcast LSB tag 6 → entries 0..7 issue on 8 consecutive edges in index order and `out_full` drops after the first issue.
- Clear and rdy:
  - With 3 ready entries, pulse `in_clear` → NOP next edge and no later issue.
  - Separately, hold `rdy`=0 for 3 cycles with a ready entry → outputs frozen, and issue resumes on the first edge with `rdy`=1.
